// File: rtl/int_sqrt_pkg.sv
// Shared types and elaboration helpers for the integer square-root engine.
package int_sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } sqrt_state_e;

   // Legal geometry: even radicand width of at least 4, and UNROLL dividing the root width.
   function automatic bit sqrt_params_ok(input int width, input int unroll);
      if (width < 4)                   return 1'b0;
      if ((width % 2) != 0)            return 1'b0;
      if (unroll < 1)                  return 1'b0;
      if (((width / 2) % unroll) != 0) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/int_sqrt_step.sv
// One non-restoring square-root step: consumes one radicand bit-pair, yields one root bit.
module int_sqrt_step #(
   parameter int QW = 12
) (
   input  logic signed [QW+1:0] rem,
   input  logic        [QW-1:0] root,
   input  logic        [1:0]    pair,
   output logic signed [QW+1:0] rem_nxt,
   output logic        [QW-1:0] root_nxt
);

   localparam int RW = QW + 2;

   logic signed [RW-1:0] shifted;

   // Subtract (4Q+1) after a non-negative remainder, add back (4Q+3) after a negative one.
   // The remainder provably stays within RW bits, so modular RW-bit arithmetic is exact.
   always_comb begin
      shifted = $signed({rem[RW-3:0], pair});
      if (!rem[RW-1]) begin
         rem_nxt = shifted - $signed({root, 2'b01});
      end else begin
         rem_nxt = shifted + $signed({root, 2'b11});
      end
      root_nxt = {root[QW-2:0], ~rem_nxt[RW-1]};
   end

endmodule

// File: rtl/int_sqrt_pipe.sv
// Iterative non-restoring integer square root with ready/valid on both sides.
// UNROLL root bits are resolved per RUN cycle; a single FIX cycle turns the
// signed partial remainder into the true non-negative remainder.
module int_sqrt_pipe
   import int_sqrt_pkg::*;
#(
   parameter int WIDTH  = 24,
   parameter int UNROLL = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [WIDTH-1:0]     n_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [WIDTH/2-1:0]   q_o,
   output logic [WIDTH/2:0]     r_o,
   output logic                 exact_o
);

   localparam int QW   = WIDTH / 2;
   localparam int RW   = QW + 2;
   localparam int ITER = QW / UNROLL;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   if (!sqrt_params_ok(WIDTH, UNROLL)) begin : g_param_check
      $error("int_sqrt_pipe: WIDTH must be even and >= 4, and UNROLL must divide WIDTH/2");
   end

   sqrt_state_e          state, state_nxt;
   logic [WIDTH-1:0]     opnd;
   logic signed [RW-1:0] rem;
   logic [QW-1:0]        root;
   logic [CW-1:0]        cnt;
   logic signed [RW-1:0] rem_fix;

   logic signed [RW-1:0] rem_ch  [UNROLL+1];
   logic [QW-1:0]        root_ch [UNROLL+1];

   assign ready_o = (state == IDLE);

   assign rem_ch[0]  = rem;
   assign root_ch[0] = root;

   // Operand is shifted left after every RUN cycle, so step i always takes pair i from the top.
   for (genvar i = 0; i < UNROLL; i++) begin : g_step
      int_sqrt_step #(.QW(QW)) u_step (
         .rem      (rem_ch[i]),
         .root     (root_ch[i]),
         .pair     (opnd[WIDTH-1-2*i -: 2]),
         .rem_nxt  (rem_ch[i+1]),
         .root_nxt (root_ch[i+1])
      );
   end

   // Final correction: a negative remainder means the last trial overshot by 2Q+1.
   always_comb begin
      rem_fix = rem;
      if (rem[RW-1]) begin
         rem_fix = rem + $signed({1'b0, root, 1'b1});
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; flush overrides every other transition.
   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (valid_i)   state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = FIX;
            FIX:                    state_nxt = DONE;
            DONE:    if (ready_i)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
         endcase
      end
   end

   // Operand, partial remainder/root, iteration counter and result registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         opnd    <= '0;
         rem     <= '0;
         root    <= '0;
         cnt     <= '0;
         valid_o <= 1'b0;
         q_o     <= '0;
         r_o     <= '0;
         exact_o <= 1'b0;
      end else if (flush_i) begin
         rem     <= '0;
         root    <= '0;
         cnt     <= '0;
         valid_o <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (valid_i) begin
                  opnd <= n_i;
                  rem  <= '0;
                  root <= '0;
                  cnt  <= CW'(ITER - 1);
               end
            end
            RUN: begin
               rem  <= rem_ch[UNROLL];
               root <= root_ch[UNROLL];
               opnd <= opnd << (2 * UNROLL);
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               q_o     <= root;
               r_o     <= rem_fix[QW:0];
               exact_o <= (rem_fix == '0);
               valid_o <= 1'b1;
            end
            DONE: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_int_sqrt_pipe.sv
// Self-checking bench for int_sqrt_pipe: reference root from real-valued sqrt
// with integer fix-up, scoreboard monitor on the main instance, and directed
// latency/value checks on two further geometries.
module tb_int_sqrt_pipe;

   localparam int W    = 24;
   localparam int U    = 1;
   localparam int QW   = W / 2;
   localparam int ITER = QW / U;

   logic            clk_i = 1'b0;
   logic            reset_i;
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic [W-1:0]    n_i;
   logic            valid_o;
   logic            ready_i;
   logic [QW-1:0]   q_o;
   logic [QW:0]     r_o;
   logic            exact_o;

   // Second instance: WIDTH=24, UNROLL=3. Third: WIDTH=8, UNROLL=4.
   logic            b_valid_i, b_ready_o, b_valid_o, b_exact_o;
   logic [23:0]     b_n_i;
   logic [11:0]     b_q_o;
   logic [12:0]     b_r_o;
   logic            c_valid_i, c_ready_o, c_valid_o, c_exact_o;
   logic [7:0]      c_n_i;
   logic [3:0]      c_q_o;
   logic [4:0]      c_r_o;

   logic            xsel;
   logic            x_valid_i;
   logic [23:0]     x_n;
   logic            x_ready, x_valid, x_exact;
   logic [11:0]     x_q;
   logic [12:0]     x_r;

   int              n_checks = 0;
   int              n_fail   = 0;
   int              cyc      = 0;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   int_sqrt_pipe #(.WIDTH(W), .UNROLL(U)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i),
      .ready_o(ready_o), .n_i(n_i), .valid_o(valid_o), .ready_i(ready_i),
      .q_o(q_o), .r_o(r_o), .exact_o(exact_o)
   );

   int_sqrt_pipe #(.WIDTH(24), .UNROLL(3)) dut_b (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(1'b0), .valid_i(b_valid_i),
      .ready_o(b_ready_o), .n_i(b_n_i), .valid_o(b_valid_o), .ready_i(1'b1),
      .q_o(b_q_o), .r_o(b_r_o), .exact_o(b_exact_o)
   );

   int_sqrt_pipe #(.WIDTH(8), .UNROLL(4)) dut_c (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(1'b0), .valid_i(c_valid_i),
      .ready_o(c_ready_o), .n_i(c_n_i), .valid_o(c_valid_o), .ready_i(1'b1),
      .q_o(c_q_o), .r_o(c_r_o), .exact_o(c_exact_o)
   );

   assign b_valid_i = x_valid_i & ~xsel;
   assign c_valid_i = x_valid_i & xsel;
   assign b_n_i     = x_n;
   assign c_n_i     = x_n[7:0];
   assign x_ready   = xsel ? c_ready_o : b_ready_o;
   assign x_valid   = xsel ? c_valid_o : b_valid_o;
   assign x_exact   = xsel ? c_exact_o : b_exact_o;
   assign x_q       = xsel ? 12'(c_q_o) : b_q_o;
   assign x_r       = xsel ? 13'(c_r_o) : b_r_o;

   // Reference: floor(sqrt(n)) from real arithmetic, nudged to the exact integer.
   function automatic longint isqrt(input longint n);
      longint q;
      q = longint'($floor($sqrt(real'(n))));
      while (q * q > n) q--;
      while ((q + 1) * (q + 1) <= n) q++;
      return q;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor for the main instance, sampled on the falling edge.
   longint sb_n[$];
   int     sb_due[$];
   bit     front_seen = 1'b0;
   longint mq;

   always @(negedge clk_i) begin
      if (reset_i) begin
         sb_n.delete();
         sb_due.delete();
         front_seen = 1'b0;
      end else begin
         chk("ready_o_vs_busy", ready_o, (sb_n.size() == 0));
         if (valid_o) begin
            if (sb_n.size() == 0) begin
               chk("spurious_valid_o", valid_o, 0);
            end else begin
               mq = isqrt(sb_n[0]);
               chk("mon_q", q_o, mq);
               chk("mon_r", r_o, sb_n[0] - mq * mq);
               chk("mon_exact", exact_o, (sb_n[0] == mq * mq));
               if (!front_seen) begin
                  chk("mon_latency", cyc, sb_due[0]);
                  front_seen = 1'b1;
               end
            end
         end else if (sb_n.size() > 0 && cyc > sb_due[0]) begin
            chk("mon_result_timeout", valid_o, 1);
            void'(sb_n.pop_front());
            void'(sb_due.pop_front());
            front_seen = 1'b0;
         end
         if (flush_i) begin
            sb_n.delete();
            sb_due.delete();
            front_seen = 1'b0;
         end else begin
            if (valid_o && ready_i && sb_n.size() > 0) begin
               void'(sb_n.pop_front());
               void'(sb_due.pop_front());
               front_seen = 1'b0;
            end
            if (valid_i && ready_o) begin
               sb_n.push_back(longint'(n_i));
               sb_due.push_back(cyc + ITER + 2);
            end
         end
      end
   end

   int acc_cyc;
   int res_cyc;

   // Present one operand to the main instance once it is ready; scramble n_i afterwards.
   task automatic send(input logic [W-1:0] n);
      int k;
      for (k = 0; k < 60; k++) begin
         if (ready_o) break;
         @(posedge clk_i); #1;
      end
      if (k == 60) chk("send_wait_ready", ready_o, 1);
      valid_i = 1'b1;
      n_i     = n;
      @(posedge clk_i); #1;
      acc_cyc = cyc;
      valid_i = 1'b0;
      n_i     = ~n;
   endtask

   // Wait (bounded) for the main result and pin it against hand-computed literals.
   task automatic wait_result(input string tag, input longint eq, input longint er, input longint ee);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge clk_i);
         if (valid_o) break;
      end
      if (k == 60) chk({tag, "_wait_valid"}, valid_o, 1);
      res_cyc = cyc;
      chk({tag, "_q"}, q_o, eq);
      chk({tag, "_r"}, r_o, er);
      chk({tag, "_exact"}, exact_o, ee);
   endtask

   // One operand through the auxiliary instances with latency and value checks.
   task automatic run_x(input bit s, input longint n, input int iter);
      int k;
      int lat;
      longint qe;
      xsel = s;
      x_n  = 24'(n);
      for (k = 0; k < 20; k++) begin
         if (x_ready) break;
         @(posedge clk_i); #1;
      end
      if (k == 20) chk("x_wait_ready", x_ready, 1);
      x_valid_i = 1'b1;
      @(posedge clk_i); #1;
      x_valid_i = 1'b0;
      lat = 0;
      while (!x_valid && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
      end
      qe = isqrt(n);
      chk(s ? "w8u4_latency" : "w24u3_latency", lat, iter + 1);
      chk(s ? "w8u4_q" : "w24u3_q", x_q, qe);
      chk(s ? "w8u4_r" : "w24u3_r", x_r, n - qe * qe);
      chk(s ? "w8u4_exact" : "w24u3_exact", x_exact, (n == qe * qe));
   endtask

   initial begin
      longint vec_n [4] = '{144, 0, 2, 999999};
      longint vec_q [4] = '{12, 0, 1, 999};
      longint vec_r [4] = '{0, 0, 1, 1998};
      longint vec_e [4] = '{1, 1, 0, 0};
      int k;

      reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; n_i = '0; ready_i = 1'b1;
      xsel = 1'b0; x_valid_i = 1'b0; x_n = '0;

      // Pin the reference model itself.
      chk("model_ffffff", isqrt(64'hFFFFFF), 64'hFFF);
      chk("model_999999", isqrt(999999), 999);
      chk("model_1000000", isqrt(1000000), 1000);

      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_ready_o", ready_o, 1);
      chk("reset_valid_o", valid_o, 0);
      chk("reset_q_o", q_o, 0);
      chk("reset_r_o", r_o, 0);
      chk("reset_exact_o", exact_o, 0);
      reset_i = 1'b0;
      @(posedge clk_i); #1;

      // Largest radicand and exact latency.
      send(24'hFFFFFF);
      wait_result("max", 64'hFFF, 64'h1FFE, 0);
      chk("max_latency_edges", res_cyc - acc_cyc, 13);
      @(posedge clk_i); #1;

      // Back-to-back operands.
      for (int i = 0; i < 4; i++) begin
         send(W'(vec_n[i]));
         wait_result("b2b", vec_q[i], vec_r[i], vec_e[i]);
         @(posedge clk_i); #1;
      end

      // Backpressure: result must be held while ready_i is low.
      ready_i = 1'b0;
      send(24'd1000000);
      wait_result("bp", 1000, 0, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         chk("bp_hold_valid", valid_o, 1);
         chk("bp_hold_q", q_o, 1000);
         chk("bp_hold_r", r_o, 0);
         chk("bp_hold_ready_o", ready_o, 0);
      end
      @(posedge clk_i); #1;
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("bp_release_valid", valid_o, 0);
      chk("bp_release_ready_o", ready_o, 1);
      chk("bp_keep_q", q_o, 1000);

      // Flush mid-RUN: the in-flight operand must never produce a result.
      send(24'd50);
      repeat (4) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      chk("flush_ready_o", ready_o, 1);
      repeat (20) @(posedge clk_i);
      #1;
      chk("flush_no_valid", valid_o, 0);
      chk("flush_keeps_q", q_o, 1000);

      // flush_i together with valid_i in IDLE: no acceptance.
      flush_i = 1'b1; valid_i = 1'b1; n_i = 24'd77;
      @(posedge clk_i); #1;
      flush_i = 1'b0; valid_i = 1'b0;
      chk("flush_vs_valid_ready_o", ready_o, 1);
      repeat (15) @(posedge clk_i);
      #1;
      chk("flush_vs_valid_no_result", valid_o, 0);

      send(24'd49);
      wait_result("after_flush", 7, 0, 1);
      chk("after_flush_latency", res_cyc - acc_cyc, ITER + 1);
      @(posedge clk_i); #1;

      // Asynchronous reset while a result waits in DONE.
      ready_i = 1'b0;
      send(24'd144);
      wait_result("pre_reset", 12, 0, 1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("async_reset_valid_o", valid_o, 0);
      chk("async_reset_q_o", q_o, 0);
      chk("async_reset_r_o", r_o, 0);
      chk("async_reset_exact_o", exact_o, 0);
      chk("async_reset_ready_o", ready_o, 1);
      @(posedge clk_i); @(posedge clk_i); #1;
      reset_i = 1'b0;
      ready_i = 1'b1;
      repeat (20) @(posedge clk_i);
      #1;
      chk("post_reset_no_valid", valid_o, 0);

      // Sweep on the main instance: boundaries, squares and random operands.
      send(24'd1);  @(negedge clk_i);
      send(24'd3);  @(negedge clk_i);
      send(24'd4);  @(negedge clk_i);
      send(24'hFFE001);
      for (int i = 0; i < 250; i++) begin
         send(W'($urandom));
      end
      for (k = 0; k < 60; k++) begin
         if (sb_n.size() == 0) break;
         @(posedge clk_i);
      end
      #1;
      if (k == 60) chk("drain_scoreboard", sb_n.size(), 0);

      // WIDTH=24, UNROLL=3.
      run_x(1'b0, 64'hFFFFFF, 4);
      run_x(1'b0, 0, 4);
      run_x(1'b0, 999999, 4);
      for (int i = 0; i < 120; i++) begin
         run_x(1'b0, longint'($urandom_range(24'hFFFFFF, 0)), 4);
      end

      // WIDTH=8, UNROLL=4: exhaustive.
      for (int i = 0; i < 256; i++) begin
         run_x(1'b1, i, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
